// File: rtl/byte_align_detect.sv
// Byte-alignment detector: finds SYNC_WORD at any of 4 byte offsets and locks onto its period.
// Latency: sync_pulse, locked and delay_time are registered 1 clk after the deciding data_in word.
// Backpressure: none; one word is accepted every cycle. Optional stats port group: BYTE_ALIGN_STATS_EN.
module byte_align_detect #(
    parameter logic [31:0] SYNC_WORD   = 32'hEB90_EB90,
    parameter int          FRAME_WORDS = 16,
    parameter int          LOCK_CNT    = 4,
    parameter int          MISS_MAX    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic [2:0]  delay_time,
    output logic        locked,
    output logic        sync_pulse
`ifdef BYTE_ALIGN_STATS_EN
    ,
    output logic [15:0] relock_cnt,
    output logic        slip_flag
`endif
);

    localparam logic [7:0] FCNT_LOAD = 8'(FRAME_WORDS - 1);
    localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_TGT  = 4'(MISS_MAX);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    // Only the low three bytes of the previous word can ever complete a candidate.
    logic [23:0] r_data_r1;
    logic [7:0]  r_fcnt, w_fcnt_nxt;
    logic [3:0]  r_hcnt, w_hcnt_nxt;
    logic [3:0]  r_mcnt, w_mcnt_nxt;
    logic [1:0]  r_cand, w_cand_nxt;
    logic [2:0]  r_delay_time, w_delay_nxt;
    logic        r_sync_pulse, w_pulse_nxt;

    logic [31:0] w_cwin [4];
    logic [3:0]  w_hit;
    logic        w_any_hit;
    logic [1:0]  w_hit_k;
    logic        w_hit_cand;
    logic        w_slot;

    // Candidate words for each byte offset across the previous/current word window.
    always_comb begin
        w_cwin[0] = data_in;
        w_cwin[1] = {r_data_r1[7:0],  data_in[31:8]};
        w_cwin[2] = {r_data_r1[15:0], data_in[31:16]};
        w_cwin[3] = {r_data_r1[23:0], data_in[31:24]};
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = (w_cwin[k] == SYNC_WORD);
        end
    end

    // Lowest matching offset wins when several candidates hit together.
    always_comb begin
        w_hit_k = 2'd0;
        if (w_hit[3]) w_hit_k = 2'd3;
        if (w_hit[2]) w_hit_k = 2'd2;
        if (w_hit[1]) w_hit_k = 2'd1;
        if (w_hit[0]) w_hit_k = 2'd0;
    end

    assign w_any_hit  = |w_hit;
    assign w_hit_cand = w_hit[r_cand];
    assign w_slot     = (r_fcnt == 8'd0);

    // Next-state logic: search for any offset, verify its period, then track it while locked.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_hcnt_nxt  = r_hcnt;
        w_mcnt_nxt  = r_mcnt;
        w_cand_nxt  = r_cand;
        w_delay_nxt = r_delay_time;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_any_hit) begin
                    w_cand_nxt  = w_hit_k;
                    w_fcnt_nxt  = FCNT_LOAD;
                    w_hcnt_nxt  = 4'd1;
                    w_state_nxt = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_slot) begin
                    w_fcnt_nxt = FCNT_LOAD;
                    if (w_hit_cand) begin
                        w_hcnt_nxt = r_hcnt + 4'd1;
                        if (r_hcnt + 4'd1 == LOCK_TGT) begin
                            w_state_nxt = ST_LOCKED;
                            w_delay_nxt = {1'b0, r_cand};
                            w_mcnt_nxt  = 4'd0;
                            w_pulse_nxt = 1'b1;
                        end
                    end else begin
                        // Failed verify: treat this same window as a fresh search cycle.
                        w_state_nxt = ST_SEARCH;
                        if (w_any_hit) begin
                            w_cand_nxt  = w_hit_k;
                            w_fcnt_nxt  = FCNT_LOAD;
                            w_hcnt_nxt  = 4'd1;
                            w_state_nxt = ST_VERIFY;
                        end
                    end
                end else begin
                    w_fcnt_nxt = r_fcnt - 8'd1;
                end
            end
            ST_LOCKED: begin
                if (w_slot) begin
                    w_fcnt_nxt = FCNT_LOAD;
                    if (w_hit_cand) begin
                        w_mcnt_nxt  = 4'd0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_mcnt_nxt = r_mcnt + 4'd1;
                        if (r_mcnt + 4'd1 == MISS_TGT) begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end else begin
                    w_fcnt_nxt = r_fcnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SEARCH;
            r_data_r1    <= 24'd0;
            r_fcnt       <= 8'd0;
            r_hcnt       <= 4'd0;
            r_mcnt       <= 4'd0;
            r_cand       <= 2'd0;
            r_delay_time <= 3'd0;
            r_sync_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_r1    <= data_in[23:0];
            r_fcnt       <= w_fcnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_mcnt       <= w_mcnt_nxt;
            r_cand       <= w_cand_nxt;
            r_delay_time <= w_delay_nxt;
            r_sync_pulse <= w_pulse_nxt;
        end
    end

    assign delay_time = r_delay_time;
    assign locked     = (r_state == ST_LOCKED);
    assign sync_pulse = r_sync_pulse;

`ifdef BYTE_ALIGN_STATS_EN
    logic        w_lock_entry;
    logic        w_lock_lost;
    logic [15:0] r_relock_cnt;
    logic        r_slip_flag;
    logic        r_prev_valid;

    assign w_lock_entry = (r_state == ST_VERIFY) && (w_state_nxt == ST_LOCKED);
    assign w_lock_lost  = (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

    // Count lock losses (saturating) and flag a new lock landing on a different offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_relock_cnt <= 16'd0;
            r_slip_flag  <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            if (w_lock_lost && (r_relock_cnt != 16'hFFFF)) begin
                r_relock_cnt <= r_relock_cnt + 16'd1;
            end
            r_slip_flag <= w_lock_entry && r_prev_valid && ({1'b0, r_cand} != r_delay_time);
            if (w_lock_entry) begin
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign relock_cnt = r_relock_cnt;
    assign slip_flag  = r_slip_flag;
`endif

endmodule

// File: doc/byte_align_detect.md
BYTE_ALIGN_DETECT -- requirements
Module: byte_align_detect

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'hEB90_EB90, the aligned frame sync word.
REQ-002 SHALL have parameter FRAME_WORDS, default 16, the sync period in clk cycles, legal 2..256.
REQ-003 SHALL have parameter LOCK_CNT, default 4, the consecutive periodic hits needed to lock, legal 2..15.
REQ-004 SHALL have parameter MISS_MAX, default 3, the consecutive periodic misses that drop lock, legal 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, 32 bits: the raw deserialized word, one per cycle, byte 3 first in time.
REQ-008 SHALL have port delay_time, output, 3 bits: the byte offset, 0..3, for the downstream byte-shift stage.
REQ-009 SHALL have port locked, output, 1 bit: alignment locked.
REQ-010 SHALL have port sync_pulse, output, 1 bit: a one-cycle pulse marking the frame-start word.

Function
REQ-011 SHALL register data_in into data_r1 every cycle and form window W = {data_r1, data_in}.
REQ-012 SHALL evaluate candidates k=0..3 combinationally as C0=data_in and Ck={data_r1[8k-1:0], data_in[31:8k]}; hit_k = (Ck == SYNC_WORD).
REQ-013 SHALL, when several candidates hit in one cycle, select the lowest k.
REQ-014 SHALL implement the FSM states SEARCH, VERIFY and LOCKED, with a frame counter fcnt (8 b), a hit counter hcnt (4 b), a miss counter mcnt (4 b) and a candidate register cand (2 b).
REQ-015 SHALL, in SEARCH, on any hit: load cand=k, fcnt=FRAME_WORDS-1 and hcnt=1, then go to VERIFY; with no hit, remain in SEARCH.
REQ-016 SHALL decrement fcnt each cycle in VERIFY/LOCKED and reload it with FRAME_WORDS-1 when it is 0 (the expected slot).
REQ-017 SHALL, in VERIFY, at the expected slot: if hit_cand, increment hcnt; when hcnt+1 == LOCK_CNT, go to LOCKED, set delay_time=cand and set mcnt=0.
REQ-018 SHALL, in VERIFY, at the expected slot when hit_cand is false, return to SEARCH, and in that same cycle re-evaluate the current window as a SEARCH cycle.
REQ-019 SHALL ignore hits at non-expected slots in VERIFY and LOCKED.
REQ-020 SHALL, in LOCKED, at the expected slot: clear mcnt on hit_cand; on a miss, increment mcnt and go to SEARCH when mcnt+1 == MISS_MAX.
REQ-021 SHALL drive locked=1 exactly while in LOCKED; the cycle after the transition out of LOCKED it SHALL read 0.
REQ-022 SHALL update delay_time only on entry to LOCKED; it holds its value through SEARCH/VERIFY after loss of lock.
REQ-023 SHALL register sync_pulse one cycle after the input cycle holding the hit at the expected slot, in the locking transition and in LOCKED hits only, so it coincides with the downstream stage's one-cycle output latency.
REQ-024 SHALL not assert sync_pulse for LOCKED misses, in SEARCH, or in VERIFY before lock.
REQ-025 SHALL have a fixed sync_pulse latency of 1 clk from data_in; locked and delay_time change 1 clk after the deciding input.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=SEARCH, delay_time=0, locked=0, sync_pulse=0, fcnt/hcnt/mcnt/cand=0 and data_r1=0.
REQ-027 SHALL, on reset asserted mid-lock or mid-verify, abandon everything and start over from SEARCH on the first cycle after rst falls.

Configuration
REQ-028 SHALL, with macro BYTE_ALIGN_STATS_EN defined, add output relock_cnt[15:0] (saturating count of LOCKED->SEARCH transitions) and output slip_flag (1-cycle pulse when a new lock yields a delay_time different from the previous lock), both cleared by rst.
REQ-029 SHALL, with BYTE_ALIGN_STATS_EN undefined, omit both ports and their logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: stream with SYNC_WORD aligned (k=0) every 16 words -> locked=1 on 4th hit, delay_time=0, sync_pulse every 16 cycles.
REQ-031 SHALL cover: stream shifted by 2 bytes (C2 matches) -> delay_time=2 at lock; downstream byte-shift output equals 32'hEB90_EB90 in the sync_pulse cycle.
REQ-032 SHALL cover: locked, then 2 missing syncs followed by a hit -> locked stays 1, mcnt returns 0; then 3 consecutive misses -> locked=0 one cycle after the 3rd expected slot.
REQ-033 SHALL cover: spurious SYNC_WORD at non-expected slot while LOCKED -> no sync_pulse, no state change.
REQ-034 SHALL cover: VERIFY with hit missing at 2nd expected slot while another offset hits that cycle -> return to SEARCH and immediately adopt the new cand.
REQ-035 SHALL cover: rst pulsed for 1 cycle while LOCKED with delay_time=3 -> delay_time=0, locked=0; relock to 3 after 4 periods; with BYTE_ALIGN_STATS_EN, relock_cnt unchanged by reset path (cleared to 0).
